// File: rtl/gpu_pkg.sv
// -----------------------------------------------------------------------------
// gpu_pkg
//   Shared encodings and width defaults for the per-core pipeline blocks.
//   - core_state_t    : 3-bit core control FSM state (IDLE .. DONE)
//   - fetcher_state_t : 2-bit instruction fetcher status reported to the core
//   - DEFAULT_ADDR_BITS / DEFAULT_DATA_BITS : program address / word widths
// -----------------------------------------------------------------------------
package gpu_pkg;

  localparam int DEFAULT_ADDR_BITS = 8;
  localparam int DEFAULT_DATA_BITS = 16;

  typedef enum logic [2:0] {
    CORE_IDLE    = 3'b000,
    CORE_FETCH   = 3'b001,
    CORE_DECODE  = 3'b010,
    CORE_REQUEST = 3'b011,
    CORE_WAIT    = 3'b100,
    CORE_EXECUTE = 3'b101,
    CORE_UPDATE  = 3'b110,
    CORE_DONE    = 3'b111
  } core_state_t;

  // FETCHER_ILLEGAL is listed so the illegal code has a name in the FSM;
  // it is never entered on purpose and recovers to FETCHER_IDLE.
  typedef enum logic [1:0] {
    FETCHER_IDLE     = 2'b00,
    FETCHER_FETCHING = 2'b01,
    FETCHER_FETCHED  = 2'b10,
    FETCHER_ILLEGAL  = 2'b11
  } fetcher_state_t;

endpackage : gpu_pkg

// File: rtl/icache_dm.sv
// -----------------------------------------------------------------------------
// icache_dm
//   Direct-mapped instruction cache used by instruction_fetcher when built
//   with FETCHER_ICACHE_EN. Index = low log2(CACHE_LINES) address bits, tag =
//   the remaining upper bits. Lines are filled only through the fill port and
//   invalidated only by reset.
//
//   Ports:
//     clk, reset           : clock, asynchronous active-high reset (valid bits)
//     lookup_addr          : address to look up (combinational)
//     hit, hit_data        : lookup result, valid in the same cycle
//     fill_en              : write fill_data into the line for fill_addr
//     fill_addr, fill_data : fill address and instruction word
// -----------------------------------------------------------------------------
module icache_dm #(
  parameter int ADDR_BITS   = 8,
  parameter int DATA_BITS   = 16,
  parameter int CACHE_LINES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] lookup_addr,
  output logic                 hit,
  output logic [DATA_BITS-1:0] hit_data,
  input  logic                 fill_en,
  input  logic [ADDR_BITS-1:0] fill_addr,
  input  logic [DATA_BITS-1:0] fill_data
);

  localparam int INDEX_BITS = $clog2(CACHE_LINES);
  localparam int TAG_BITS   = ADDR_BITS - INDEX_BITS;

  logic [CACHE_LINES-1:0] valid_reg;
  logic [CACHE_LINES-1:0] line_fill;
  logic [TAG_BITS-1:0]    tag_mem  [CACHE_LINES];
  logic [DATA_BITS-1:0]   data_mem [CACHE_LINES];

  logic [INDEX_BITS-1:0] lookup_index;
  logic [TAG_BITS-1:0]   lookup_tag;
  logic [INDEX_BITS-1:0] fill_index;
  logic [TAG_BITS-1:0]   fill_tag;

  assign lookup_index = lookup_addr[INDEX_BITS-1:0];
  assign lookup_tag   = lookup_addr[ADDR_BITS-1:INDEX_BITS];
  assign fill_index   = fill_addr[INDEX_BITS-1:0];
  assign fill_tag     = fill_addr[ADDR_BITS-1:INDEX_BITS];

  // One-hot line select for the valid-bit update.
  genvar gi;
  generate
    for (gi = 0; gi < CACHE_LINES; gi++) begin : g_line_sel
      localparam logic [INDEX_BITS-1:0] LINE_INDEX = INDEX_BITS'(gi);
      assign line_fill[gi] = fill_en && (fill_index == LINE_INDEX);
    end
  endgenerate

  // Only the valid bits need reset; tag/data contents are don't-care until
  // the matching valid bit is set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg <= '0;
    end else begin
      valid_reg <= valid_reg | line_fill;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[fill_index]  <= fill_tag;
      data_mem[fill_index] <= fill_data;
    end
  end

  // Combinational read port: the fetcher decides hit/miss in the same cycle
  // it samples FETCH.
  assign hit      = valid_reg[lookup_index] && (tag_mem[lookup_index] == lookup_tag);
  assign hit_data = data_mem[lookup_index];

endmodule : icache_dm

// File: rtl/instruction_fetcher.sv
// -----------------------------------------------------------------------------
// instruction_fetcher
//   Per-core fetch stage. On a FETCH phase it reads one instruction word from
//   program memory over a valid/ready handshake and reports completion via
//   fetcher_state. All outputs are registered.
//
//   Build option: define FETCHER_ICACHE_EN to include a direct-mapped
//   instruction cache (icache_dm) so repeated PCs skip the memory round trip.
//
//   Ports:
//     clk, reset        : clock, asynchronous active-high reset
//     core_state        : core FSM state (FETCH=001, DECODE=010)
//     current_pc        : address of the instruction to fetch
//     mem_read_valid    : program memory read request
//     mem_read_address  : request address (held while the request is open)
//     mem_read_ready    : memory returns data this cycle
//     mem_read_data     : returned instruction word
//     fetcher_state     : IDLE=00, FETCHING=01, FETCHED=10
//     instruction       : last fetched instruction word
// -----------------------------------------------------------------------------
module instruction_fetcher
  import gpu_pkg::*;
#(
  parameter int ADDR_BITS   = DEFAULT_ADDR_BITS,
  parameter int DATA_BITS   = DEFAULT_DATA_BITS,
  parameter int CACHE_LINES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           core_state,
  input  logic [ADDR_BITS-1:0] current_pc,
  output logic                 mem_read_valid,
  output logic [ADDR_BITS-1:0] mem_read_address,
  input  logic                 mem_read_ready,
  input  logic [DATA_BITS-1:0] mem_read_data,
  output logic [1:0]           fetcher_state,
  output logic [DATA_BITS-1:0] instruction
);

  fetcher_state_t       state_reg,            state_next;
  logic                 mem_read_valid_reg,   mem_read_valid_next;
  logic [ADDR_BITS-1:0] mem_read_address_reg, mem_read_address_next;
  logic [DATA_BITS-1:0] instruction_reg,      instruction_next;

  logic cache_hit;
  logic [DATA_BITS-1:0] cache_data;
  logic fill_en;

`ifdef FETCHER_ICACHE_EN
  // The fill address is the registered request address: current_pc may
  // already have moved on by the time memory answers.
  icache_dm #(
    .ADDR_BITS   (ADDR_BITS),
    .DATA_BITS   (DATA_BITS),
    .CACHE_LINES (CACHE_LINES)
  ) u_icache (
    .clk         (clk),
    .reset       (reset),
    .lookup_addr (current_pc),
    .hit         (cache_hit),
    .hit_data    (cache_data),
    .fill_en     (fill_en),
    .fill_addr   (mem_read_address_reg),
    .fill_data   (mem_read_data)
  );
`else
  assign cache_hit  = 1'b0;
  assign cache_data = '0;

  // CACHE_LINES only sizes the cache; this keeps the parameter referenced so
  // both builds share one parameter list.
  if (CACHE_LINES < 2) begin : g_cache_lines_unused
  end
`endif

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg            <= FETCHER_IDLE;
      mem_read_valid_reg   <= 1'b0;
      mem_read_address_reg <= '0;
      instruction_reg      <= '0;
    end else begin
      state_reg            <= state_next;
      mem_read_valid_reg   <= mem_read_valid_next;
      mem_read_address_reg <= mem_read_address_next;
      instruction_reg      <= instruction_next;
    end
  end

  always_comb begin
    state_next            = state_reg;
    mem_read_valid_next   = mem_read_valid_reg;
    mem_read_address_next = mem_read_address_reg;
    instruction_next      = instruction_reg;
    fill_en               = 1'b0;

    case (state_reg)
      FETCHER_IDLE: begin
        if (core_state == CORE_FETCH) begin
          if (cache_hit) begin
            instruction_next = cache_data;
            state_next       = FETCHER_FETCHED;
          end else begin
            mem_read_address_next = current_pc;
            mem_read_valid_next   = 1'b1;
            state_next            = FETCHER_FETCHING;
          end
        end
      end

      // core_state is ignored here: an open request always runs to completion.
      FETCHER_FETCHING: begin
        if (mem_read_valid_reg && mem_read_ready) begin
          instruction_next    = mem_read_data;
          mem_read_valid_next = 1'b0;
          state_next          = FETCHER_FETCHED;
          fill_en             = 1'b1;
        end
      end

      FETCHER_FETCHED: begin
        if (core_state == CORE_DECODE) begin
          state_next = FETCHER_IDLE;
        end
      end

      default: begin
        state_next          = FETCHER_IDLE;
        mem_read_valid_next = 1'b0;
      end
    endcase
  end

  assign fetcher_state    = state_reg;
  assign mem_read_valid   = mem_read_valid_reg;
  assign mem_read_address = mem_read_address_reg;
  assign instruction      = instruction_reg;

endmodule : instruction_fetcher

// File: tb/tb_instruction_fetcher.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetcher
//   Self-checking bench for instruction_fetcher. A program memory image and,
//   when FETCHER_ICACHE_EN is defined, a direct-mapped cache model decide the
//   expected hit/miss, latency, request length and instruction of each fetch.
// -----------------------------------------------------------------------------
module tb_instruction_fetcher;

  localparam int AB = 8;
  localparam int DB = 16;
  localparam int CL = 8;
  localparam int MAX_CYCLES = 40;

  localparam logic [2:0] C_IDLE    = 3'b000;
  localparam logic [2:0] C_FETCH   = 3'b001;
  localparam logic [2:0] C_DECODE  = 3'b010;
  localparam logic [2:0] C_EXECUTE = 3'b101;

  localparam logic [1:0] F_IDLE    = 2'b00;
  localparam logic [1:0] F_FETCHED = 2'b10;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    core_state;
  logic [AB-1:0] current_pc;
  logic          mem_read_valid;
  logic [AB-1:0] mem_read_address;
  logic          mem_read_ready;
  logic [DB-1:0] mem_read_data;
  logic [1:0]    fetcher_state;
  logic [DB-1:0] instruction;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  logic [DB-1:0] model_mem [256];
  logic [DB-1:0] exp_instr_last;
  bit            model_valid [CL];
  int            model_tag   [CL];

  instruction_fetcher #(
    .ADDR_BITS   (AB),
    .DATA_BITS   (DB),
    .CACHE_LINES (CL)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .core_state       (core_state),
    .current_pc       (current_pc),
    .mem_read_valid   (mem_read_valid),
    .mem_read_address (mem_read_address),
    .mem_read_ready   (mem_read_ready),
    .mem_read_data    (mem_read_data),
    .fetcher_state    (fetcher_state),
    .instruction      (instruction)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < CL; i++) begin
      model_valid[i] = 1'b0;
      model_tag[i]   = 0;
    end
    exp_instr_last = '0;
  endfunction

  function automatic bit model_hit(input logic [AB-1:0] pc);
`ifdef FETCHER_ICACHE_EN
    int idx = int'(pc) % CL;
    return model_valid[idx] && (model_tag[idx] == int'(pc) / CL);
`else
    return 1'b0;
`endif
  endfunction

  function automatic void model_fill(input logic [AB-1:0] pc);
    int idx = int'(pc) % CL;
    model_valid[idx] = 1'b1;
    model_tag[idx]   = int'(pc) / CL;
  endfunction

  // One full FETCH -> FETCHED -> hold -> DECODE -> IDLE transaction.
  task automatic do_fetch(input logic [AB-1:0] pc, input int wait_cycles,
                          input bit wander, output int vcnt_out);
    bit            exp_hit;
    logic [DB-1:0] exp_instr;
    int            exp_lat, exp_vcnt, lat, vcnt;
    bit            done, addr_bad;

    exp_hit   = model_hit(pc);
    exp_instr = model_mem[pc];
    exp_lat   = exp_hit ? 1 : wait_cycles + 2;
    exp_vcnt  = exp_hit ? 0 : wait_cycles + 1;

    @(negedge clk);
    core_state     = C_FETCH;
    current_pc     = pc;
    mem_read_ready = 1'b0;
    lat = 0; vcnt = 0; done = 0; addr_bad = 0;
    while (!done && lat < MAX_CYCLES) begin
      @(negedge clk);
      lat++;
      mem_read_ready = 1'b0;
      mem_read_data  = DB'($urandom);
      if (wander && lat == 1) core_state = C_EXECUTE;
      if (fetcher_state == F_FETCHED) begin
        done = 1;
      end else if (mem_read_valid) begin
        vcnt++;
        if (mem_read_address !== pc) addr_bad = 1;
        if (vcnt == wait_cycles + 1) begin
          mem_read_ready = 1'b1;
          mem_read_data  = model_mem[mem_read_address];
        end
      end
    end
    vcnt_out = vcnt;

    compared++;
    if (!done) begin
      mismatched++;
      $display("FAIL fetch_timeout pc=%02h: no FETCHED within %0d cycles", pc, MAX_CYCLES);
    end
    compared++;
    if (lat !== exp_lat) begin
      mismatched++;
      $display("FAIL fetch_latency pc=%02h: got %0d cycles, expected %0d", pc, lat, exp_lat);
    end
    compared++;
    if (vcnt !== exp_vcnt) begin
      mismatched++;
      $display("FAIL valid_cycles pc=%02h: got %0d, expected %0d", pc, vcnt, exp_vcnt);
    end
    compared++;
    if (addr_bad) begin
      mismatched++;
      $display("FAIL request_address pc=%02h: address %02h seen, expected %02h held", pc, mem_read_address, pc);
    end
    compared++;
    if (instruction !== exp_instr) begin
      mismatched++;
      $display("FAIL instruction pc=%02h: got %04h, expected %04h", pc, instruction, exp_instr);
    end
    compared++;
    if (mem_read_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL valid_after_fetch pc=%02h: got %b, expected 0", pc, mem_read_valid);
    end

    if (!exp_hit) model_fill(pc);
    exp_instr_last = exp_instr;

    // FETCHED must hold while the core is not in DECODE.
    core_state = C_IDLE;
    @(negedge clk);
    compared++;
    if (fetcher_state !== F_FETCHED) begin
      mismatched++;
      $display("FAIL fetched_hold pc=%02h: got state %b, expected %b", pc, fetcher_state, F_FETCHED);
    end

    core_state = C_DECODE;
    @(negedge clk);
    compared++;
    if (fetcher_state !== F_IDLE || instruction !== exp_instr) begin
      mismatched++;
      $display("FAIL decode_to_idle pc=%02h: got state %b instr %04h, expected %b %04h",
               pc, fetcher_state, instruction, F_IDLE, exp_instr);
    end
    core_state = C_IDLE;

    $display("fetch pc=%02h wait=%0d wander=%0d hit=%0d lat=%0d vcyc=%0d instr=%04h",
             pc, wait_cycles, wander, exp_hit, lat, vcnt, instruction);
  endtask

  task automatic apply_reset();
    reset          = 1'b1;
    core_state     = C_IDLE;
    current_pc     = '0;
    mem_read_ready = 1'b0;
    mem_read_data  = '0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    compared++;
    if (fetcher_state !== F_IDLE || mem_read_valid !== 1'b0 ||
        mem_read_address !== '0 || instruction !== '0) begin
      mismatched++;
      $display("FAIL reset_state: got st=%b v=%b a=%02h i=%04h, expected 00 0 00 0000",
               fetcher_state, mem_read_valid, mem_read_address, instruction);
    end
    $display("reset: st=%b v=%b a=%02h i=%04h", fetcher_state, mem_read_valid,
             mem_read_address, instruction);
  endtask

  task automatic test_basic_fetch();
    int v;
    do_fetch(8'h05, 3, 1'b0, v);
  endtask

  task automatic test_ready_in_idle();
    @(negedge clk);
    core_state     = C_IDLE;
    mem_read_ready = 1'b1;
    mem_read_data  = 16'h5A5A ^ exp_instr_last;
    @(negedge clk);
    mem_read_ready = 1'b0;
    @(negedge clk);
    compared++;
    if (fetcher_state !== F_IDLE || mem_read_valid !== 1'b0 || instruction !== exp_instr_last) begin
      mismatched++;
      $display("FAIL ready_in_idle: got st=%b v=%b i=%04h, expected 00 0 %04h",
               fetcher_state, mem_read_valid, instruction, exp_instr_last);
    end
    $display("ready_in_idle: st=%b i=%04h", fetcher_state, instruction);
  endtask

  task automatic test_reset_mid_fetch();
    int v;
    @(negedge clk);
    core_state = C_FETCH;
    current_pc = 8'h10;
    @(negedge clk);
    compared++;
    if (mem_read_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL pre_reset_valid: got %b, expected 1", mem_read_valid);
    end
    #2 reset = 1'b1;
    model_reset();
    #1;
    compared++;
    if (mem_read_valid !== 1'b0 || fetcher_state !== F_IDLE) begin
      mismatched++;
      $display("FAIL async_reset: got v=%b st=%b, expected 0 00", mem_read_valid, fetcher_state);
    end
    $display("reset_mid_fetch: v=%b st=%b", mem_read_valid, fetcher_state);
    @(negedge clk);
    core_state = C_IDLE;
    reset      = 1'b0;
    do_fetch(8'h10, 1, 1'b0, v);
    compared++;
    if (v == 0) begin
      mismatched++;
      $display("FAIL refetch_after_reset: got %0d request cycles, expected >0", v);
    end
  endtask

  task automatic test_cache_reuse();
    int v;
    do_fetch(8'h05, 2, 1'b0, v);
    do_fetch(8'h05, 2, 1'b0, v);
  endtask

  task automatic test_index_conflict();
    int v;
    do_fetch(8'h05, 1, 1'b0, v);
    do_fetch(8'h0D, 0, 1'b0, v);
    do_fetch(8'h05, 0, 1'b0, v);
    do_fetch(8'hFF, 2, 1'b1, v);
    do_fetch(8'hFF, 0, 1'b0, v);
  endtask

  task automatic test_random();
    int v;
    logic [AB-1:0] pool [6];
    pool[0] = 8'h05; pool[1] = 8'h0D; pool[2] = 8'hFF;
    pool[3] = 8'h00; pool[4] = 8'h15; pool[5] = 8'h7A;
    for (int n = 0; n < 40; n++) begin
      logic [AB-1:0] pc;
      if ($urandom_range(0, 3) == 0) pc = AB'($urandom);
      else pc = pool[$urandom_range(0, 5)];
      do_fetch(pc, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), v);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) model_mem[i] = DB'($urandom);
    model_mem[8'h05] = 16'hA5C3;

    test_reset();
    test_basic_fetch();
    test_ready_in_idle();
    test_reset_mid_fetch();
    test_cache_reuse();
    test_index_conflict();
    test_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_instruction_fetcher

// File: doc/instruction_fetcher.md
# instruction_fetcher

Per-core instruction fetch stage sitting directly upstream of the core control FSM. It watches the core state and the current PC. On each FETCH phase it reads one instruction word from program memory over a valid/ready handshake, then reports completion to the core FSM through `fetcher_state`. An optional direct-mapped instruction cache lets repeated PCs skip the memory round trip.

## Interface
Parameters:
- `ADDR_BITS`, default 8: program address width, equal to the PC width.
- `DATA_BITS`, default 16: instruction word width.
- `CACHE_LINES`, default 8: number of cache entries; must be a power of two, 2 or more. Used only with the cache compiled in.

Ports:
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `reset`, input, 1: asynchronous, active-high.
- `core_state`, input, 3: core FSM state. FETCH=3'b001, DECODE=3'b010.
- `current_pc`, input, ADDR_BITS: address of the instruction to fetch.
- `mem_read_valid`, output, 1: program memory read request.
- `mem_read_address`, output, ADDR_BITS: request address.
- `mem_read_ready`, input, 1: memory has returned data this cycle.
- `mem_read_data`, input, DATA_BITS: returned instruction word.
- `fetcher_state`, output, 2: IDLE=2'b00, FETCHING=2'b01, FETCHED=2'b10.
- `instruction`, output, DATA_BITS: last fetched instruction.

## Operation
- All outputs are registered.
- On reset: `fetcher_state`=IDLE, `mem_read_valid`=0, `mem_read_address`=0, `instruction`=0, and every cache valid bit is cleared.

State machine:
- IDLE, when `core_state`==FETCH:
  - Without the cache, or on a cache miss: capture `current_pc` into `mem_read_address`, set `mem_read_valid`=1, go to FETCHING.
  - On a cache hit: load `instruction` from the cache, go to FETCHED. No memory request is made.
- FETCHING:
  - Hold `mem_read_valid` and `mem_read_address` stable until `mem_read_ready`=1 is sampled.
  - On that edge: `instruction`<=`mem_read_data`, `mem_read_valid`<=0, go to FETCHED. With the cache compiled in, also write the word into the cache line.
- FETCHED: hold `instruction`. When `core_state`==DECODE, go to IDLE.
- The 2'b11 encoding is illegal; it returns to IDLE on the next edge.

Boundary conditions:
- `mem_read_ready` is ignored while `mem_read_valid`=0.
- If `core_state` leaves FETCH during FETCHING, the transaction still completes. Requests are never abandoned except by reset.
- Reset during FETCHING drops `mem_read_valid` immediately, since reset is asynchronous.
- Wrap-around: PC 0xFF is an ordinary address with no special handling.

## Timing
- Uncached fetch:
  - `mem_read_valid` rises 1 cycle after `core_state`==FETCH is first sampled in IDLE.
  - `fetcher_state`=FETCHED appears on the edge that samples `mem_read_ready`.
  - Minimum latency is 2 cycles from FETCH to FETCHED, when ready arrives in the first valid cycle.
- Cache hit: FETCHED is reached 1 cycle after FETCH is sampled.
- FETCHED→IDLE takes 1 cycle after DECODE is sampled.
- At most one outstanding request at any time.

## Configuration
- Macro `FETCHER_ICACHE_EN`.
- When defined, the design contains a direct-mapped cache:
  - index = `current_pc[log2(CACHE_LINES)-1:0]`; tag = the remaining upper PC bits.
  - Each line holds a valid bit, a tag, and a data word.
  - Lines are filled only on memory returns and invalidated only by reset.
- When undefined:
  - Every FETCH goes to memory.
  - `CACHE_LINES` is unused.
  - No cache storage is synthesised.

## Structure
- Shared package `gpu_pkg` holds:
  - the core state encodings (IDLE…DONE, 3-bit);
  - the fetcher state encodings (2-bit);
  - the default address and data width constants.
- One sub-module, `icache_dm`:
  - contents: valid, tag and data arrays, a combinational hit/read port, and a synchronous fill port;
  - instantiated only under `FETCHER_ICACHE_EN`.

## Test plan
- Reset, then FETCH with `current_pc`=0x05; memory returns 0xA5C3 after 3 wait cycles. Expect `mem_read_address`=0x05 held stable, `mem_read_valid` high for exactly 4 cycles, `instruction`=0xA5C3, and FETCHED.
- FETCHED, then `core_state`=DECODE. Expect `fetcher_state`=IDLE on the next edge with `instruction` unchanged.
- Pulse `mem_read_ready`=1 while in IDLE. Expect no state change and `instruction` unchanged.
- Assert reset 1 cycle into FETCHING at PC 0x10. Expect `mem_read_valid`=0 immediately and IDLE; a later fetch of 0x10 issues a fresh request.
- With `FETCHER_ICACHE_EN`, fetch 0x05 twice. Expect the first fetch to issue a memory request and the second to make no request, with FETCHED 1 cycle after FETCH and `instruction`=0xA5C3.
- With `FETCHER_ICACHE_EN` and `CACHE_LINES`=8, fetch 0x05, then 0x0D, then 0x05; 0x05 and 0x0D share an index but have different tags. Expect all three fetches to miss and go to memory.
